ibuffer: RTL and testbench

IBUFFER -- requirements
Module: ibuffer

---
 rtl/ibuffer.sv | 81 ++++++++
 tb/tb_ibuffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ibuffer.sv
`default_nettype none
// ============================================================================
// Module   : ibuffer
// Purpose  : Instruction buffer between fetch and ctrlblock with flush support.
// Revision : 1.0
// ============================================================================
module ibuffer #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 48
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_instr_valid,
    input  logic [31:0]              fetch_inst,
    input  logic [PC_W-1:0]          fetch_pc,
    output logic                     fetch_ready,
    input  logic                     redirect_valid,
    output logic                     ibuffer_instr_valid,
    output logic [31:0]              ibuffer_inst_out,
    output logic [PC_W-1:0]          ibuffer_pc_out,
    input  logic                     ibuffer_ready,
    output logic [$clog2(DEPTH):0]   ibuffer_count
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_EW = 32 + PC_W;
    localparam logic [C_AW:0] C_FULL = (C_AW + 1)'(DEPTH);

    logic [C_EW-1:0] r_mem [DEPTH];
    logic [C_AW:0]   r_rptr;
    logic [C_AW:0]   r_wptr;
    logic [C_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;
    logic [C_EW-1:0] w_head;

    // Ready/valid depend only on registered occupancy, never on the handshakes.
    assign fetch_ready         = (r_count != C_FULL);
    assign ibuffer_instr_valid = (r_count != '0);
    assign ibuffer_count       = r_count;

    assign w_push = fetch_instr_valid && fetch_ready && !redirect_valid;
    assign w_pop  = ibuffer_instr_valid && ibuffer_ready && !redirect_valid;

    assign w_head           = r_mem[r_rptr[C_AW-1:0]];
    assign ibuffer_inst_out = w_head[C_EW-1:PC_W];
    assign ibuffer_pc_out   = w_head[PC_W-1:0];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[C_AW-1:0]] <= {fetch_inst, fetch_pc};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibuffer
// Purpose  : Directed/streamed scoreboard bench for ibuffer.
// Revision : 1.0
// ============================================================================
module tb_ibuffer;

    localparam int DEPTH = 8;
    localparam int PC_W  = 48;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = 32 + PC_W;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_instr_valid = 1'b0;
    logic [31:0]     fetch_inst = '0;
    logic [PC_W-1:0] fetch_pc = '0;
    logic            fetch_ready;
    logic            redirect_valid = 1'b0;
    logic            ibuffer_instr_valid;
    logic [31:0]     ibuffer_inst_out;
    logic [PC_W-1:0] ibuffer_pc_out;
    logic            ibuffer_ready = 1'b0;
    logic [CW-1:0]   ibuffer_count;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] sb [$];

    ibuffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .fetch_instr_valid   (fetch_instr_valid),
        .fetch_inst          (fetch_inst),
        .fetch_pc            (fetch_pc),
        .fetch_ready         (fetch_ready),
        .redirect_valid      (redirect_valid),
        .ibuffer_instr_valid (ibuffer_instr_valid),
        .ibuffer_inst_out    (ibuffer_inst_out),
        .ibuffer_pc_out      (ibuffer_pc_out),
        .ibuffer_ready       (ibuffer_ready),
        .ibuffer_count       (ibuffer_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the reference queue.
    task automatic check_state();
        check("count", 96'(ibuffer_count), 96'(sb.size()));
        check("valid", 96'(ibuffer_instr_valid), 96'(sb.size() != 0));
        check("fetch_ready", 96'(fetch_ready), 96'(sb.size() < DEPTH));
        if (sb.size() != 0) begin
            check("head_inst", 96'(ibuffer_inst_out), 96'(sb[0][EW-1:PC_W]));
            check("head_pc", 96'(ibuffer_pc_out), 96'(sb[0][PC_W-1:0]));
        end
    endtask

    // Drive one cycle of stimulus (called at posedge+1), check, then update the model.
    task automatic cycle(input logic fv, input logic [31:0] inst, input logic [PC_W-1:0] pc,
                         input logic rdy, input logic redir);
        bit push, pop;
        fetch_instr_valid = fv;
        fetch_inst        = inst;
        fetch_pc          = pc;
        ibuffer_ready     = rdy;
        redirect_valid    = redir;
        #1;
        check_state();
        push = fv && (sb.size() < DEPTH) && !redir;
        pop  = (sb.size() != 0) && rdy && !redir;
        @(posedge clock);
        #1;
        if (redir) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back({inst, pc});
        end
    endtask

    initial begin
        int sent;
        int delivered;
        logic rdy;

        #2;
        check("rst_valid", 96'(ibuffer_instr_valid), 96'(0));
        check("rst_count", 96'(ibuffer_count), 96'(0));
        check("rst_fetch_ready", 96'(fetch_ready), 96'(1));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;

        // Single flow: first push right after reset, visible exactly one cycle later.
        cycle(1'b1, 32'h0000_0013, 48'h0000_8000_0000, 1'b1, 1'b0);
        check("single_valid", 96'(ibuffer_instr_valid), 96'(1));
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("single_empty", 96'(ibuffer_count), 96'(0));

        // Fill with consumer stalled, then offer a ninth entry.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h100 + 32'(i), 48'h1000 + 48'(4 * i), 1'b0, 1'b0);
        check("full_count", 96'(ibuffer_count), 96'(8));
        check("full_fetch_ready", 96'(fetch_ready), 96'(0));
        cycle(1'b1, 32'hdead, 48'h1020, 1'b0, 1'b0);

        // Pop while full: the offered entry must not be taken this cycle.
        cycle(1'b1, 32'hbeef, 48'h1024, 1'b1, 1'b0);
        check("fullpop_count", 96'(ibuffer_count), 96'(7));
        check("fullpop_fetch_ready", 96'(fetch_ready), 96'(1));
        check("fullpop_head_pc", 96'(ibuffer_pc_out), 96'(48'h1004));
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("drain_empty", 96'(ibuffer_count), 96'(0));

        // Stream 20 entries across pointer wrap with random consumer stalls.
        sent = 0;
        delivered = 0;
        for (int n = 0; n < 300 && (sent < 20 || sb.size() != 0); n++) begin
            rdy = 1'($urandom_range(0, 1));
            if (sb.size() != 0 && rdy) delivered++;
            if (sent < 20 && sb.size() < DEPTH) begin
                cycle(1'b1, 32'h4000 + 32'(sent), 48'h3000 + 48'(4 * sent), rdy, 1'b0);
                sent++;
            end else begin
                cycle(1'b0, '0, '0, rdy, 1'b0);
            end
        end
        check("stream_delivered", 96'(delivered), 96'(20));

        // Flush with simultaneous push and pop.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h500 + 32'(i), 48'h5000 + 48'(4 * i), 1'b0, 1'b0);
        check("preflush_count", 96'(ibuffer_count), 96'(5));
        cycle(1'b1, 32'h5ff, 48'h5ff0, 1'b1, 1'b1);
        check("flush_count", 96'(ibuffer_count), 96'(0));
        check("flush_valid", 96'(ibuffer_instr_valid), 96'(0));
        cycle(1'b1, 32'h2222, 48'h2000, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("postflush_empty", 96'(ibuffer_count), 96'(0));

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h700 + 32'(i), 48'h7000 + 48'(4 * i), 1'b0, 1'b0);
        fetch_instr_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 96'(ibuffer_instr_valid), 96'(0));
        check("arst_count", 96'(ibuffer_count), 96'(0));
        check("arst_fetch_ready", 96'(fetch_ready), 96'(1));
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'h8888, 48'h8000, 1'b0, 1'b0);
        check("post_rst_pc", 96'(ibuffer_pc_out), 96'(48'h8000));
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
